// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Holds the FSM state encoding, byte-lane count and address helpers.
package dmem_pkg;

  localparam int unsigned NumLanes = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  // Word-index width for a given number of words; never narrower than one bit.
  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || (32'(addr[31:2]) >= depth);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised data storage: synchronous byte-enabled write, combinational read.
// Contents are deliberately left unreset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned Depth = 256,
  parameter int unsigned AddrW = 8
) (
  input  logic                clk_i,
  input  logic                we_i,
  input  logic [AddrW-1:0]    addr_i,
  input  logic [31:0]         wdata_i,
  input  logic [NumLanes-1:0] be_i,
  output logic [31:0]         rdata_o
);

  logic [31:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < NumLanes; i++) begin
        if (be_i[i]) begin
          mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// Memory end of the load/store interface: one outstanding request, programmable
// wait states, and a held response handshake carrying load data or an error.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [31:0]         req_addr,
  input  logic [31:0]         req_wdata,
  input  logic [NumLanes-1:0] req_be,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [31:0]         rsp_rdata,
  output logic                rsp_err
);

  localparam int unsigned AddrW = addr_width(DEPTH);
  localparam int unsigned CntW  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  state_e              state_q;
  logic [CntW-1:0]     cnt_q;
  logic                req_ready_q, rsp_valid_q, rsp_err_q;
  logic [31:0]         rsp_rdata_q;

  logic                lat_we_q, lat_err_q;
  logic [AddrW-1:0]    lat_idx_q;
  logic [31:0]         lat_wdata_q;
  logic [NumLanes-1:0] lat_be_q;

  logic                accept, commit, c_we, c_err;
  logic [AddrW-1:0]    c_idx;
  logic [31:0]         c_wdata, mem_rdata;
  logic [NumLanes-1:0] c_be;

  // With no wait states the commit uses the live request on the accept edge.
  always_comb begin
    accept = (state_q == StIdle) && req_valid && req_ready_q;
    if (WAIT_CYCLES == 0) begin
      commit  = accept;
      c_we    = req_we;
      c_err   = addr_err(req_addr, DEPTH);
      c_idx   = req_addr[AddrW+1:2];
      c_wdata = req_wdata;
      c_be    = req_be;
    end else begin
      commit  = (state_q == StWait) && (cnt_q == '0);
      c_we    = lat_we_q;
      c_err   = lat_err_q;
      c_idx   = lat_idx_q;
      c_wdata = lat_wdata_q;
      c_be    = lat_be_q;
    end
  end

  dmem_array #(
    .Depth (DEPTH),
    .AddrW (AddrW)
  ) u_array (
    .clk_i   (clk),
    .we_i    (reset && commit && c_we && !c_err),
    .addr_i  (c_idx),
    .wdata_i (c_wdata),
    .be_i    (c_be),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          req_ready_q <= 1'b1;
          if (accept) begin
            req_ready_q <= 1'b0;
            lat_we_q    <= req_we;
            lat_err_q   <= addr_err(req_addr, DEPTH);
            lat_idx_q   <= req_addr[AddrW+1:2];
            lat_wdata_q <= req_wdata;
            lat_be_q    <= req_be;
            if (WAIT_CYCLES == 0) begin
              state_q <= StResp;
            end else begin
              state_q <= StWait;
              cnt_q   <= CntW'(WAIT_CYCLES - 1);
            end
          end
        end
        StWait: begin
          if (cnt_q == '0) state_q <= StResp;
          else             cnt_q   <= cnt_q - CntW'(1);
        end
        StResp: begin
          // rsp_valid is registered one edge after entering RESP.
          if (!rsp_valid_q) begin
            rsp_valid_q <= 1'b1;
          end else if (rsp_ready) begin
            state_q     <= StIdle;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
      if (commit) begin
        rsp_err_q   <= c_err;
        rsp_rdata_q <= (c_err || c_we) ? '0 : mem_rdata;
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a cycle-level behavioural model of the handshake and
// memory, checked every cycle, plus directed literal expectations and random traffic.
module tb_dmem_responder;

  localparam int unsigned Depth = 256;
  localparam int          W     = 2;

  logic        clk = 1'b0, reset = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  logic        b_req_valid = 1'b0, b_req_we = 1'b0, b_rsp_ready = 1'b0;
  logic [31:0] b_req_addr = '0, b_req_wdata = '0;
  logic [3:0]  b_req_be = '0;
  logic        b_req_ready, b_rsp_valid, b_rsp_err;
  logic [31:0] b_rsp_rdata;

  int n_checks = 0, n_errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(Depth), .WAIT_CYCLES(W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.DEPTH(Depth), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_we(b_req_we), .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
    .rsp_err(b_rsp_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h, expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mem_m [Depth];
  bit          m_known = 0, m_rst = 0, m_pend = 0;
  int          m_age = 0;
  logic        p_we, p_err, e_err;
  int unsigned p_idx;
  logic [31:0] p_wdata, e_rdata;
  logic [3:0]  p_be;

  function automatic logic model_err(input logic [31:0] a);
    return (a % 4 != 0) || (a / 4 >= Depth);
  endfunction

  task automatic m_commit();
    logic [31:0] w;
    if (p_err) begin
      e_rdata = '0; e_err = 1'b1;
    end else if (p_we) begin
      w = mem_m[p_idx];
      for (int b = 0; b < 4; b++) if (p_be[b]) w[8*b +: 8] = p_wdata[8*b +: 8];
      mem_m[p_idx] = w;
      e_rdata = '0; e_err = 1'b0;
    end else begin
      e_rdata = mem_m[p_idx]; e_err = 1'b0;
    end
  endtask

  // Compare outputs for the current cycle, then predict what the next edge does.
  always @(negedge clk) begin
    if (m_known) begin
      if (m_rst) begin
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
      end else if (!m_pend) begin
        chk("idle_req_ready", req_ready, 1);
        chk("idle_rsp_valid", rsp_valid, 0);
      end else if (m_age <= W) begin
        chk("busy_req_ready", req_ready, 0);
        chk("busy_rsp_valid", rsp_valid, 0);
      end else begin
        chk("resp_req_ready", req_ready, 0);
        chk("resp_rsp_valid", rsp_valid, 1);
        chk("resp_rdata", rsp_rdata, e_rdata);
        chk("resp_err", rsp_err, e_err);
      end
    end
    if (!reset) begin
      m_known = 1; m_rst = 1; m_pend = 0;
    end else if (m_known) begin
      if (m_rst) begin
        m_rst = 0;
      end else if (!m_pend) begin
        if (req_valid) begin
          p_we = req_we; p_err = model_err(req_addr); p_idx = req_addr / 4;
          p_wdata = req_wdata; p_be = req_be;
          m_pend = 1; m_age = 0;
          if (W == 0) m_commit();
        end
      end else if (m_age > W && rsp_ready) begin
        m_pend = 0;
      end else begin
        m_age++;
        if (m_age == W) m_commit();
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] be, input int hold,
                     output logic [31:0] rd, output logic er, output int lat);
    int n = 0;
    rd = 'x; er = 1'bx; lat = -1;
    while (req_ready !== 1'b1 && n < 20) begin step(); n++; end
    if (req_ready !== 1'b1) begin chk("req_ready_timeout", req_ready, 1); return; end
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_be = be; rsp_ready = 1'b0;
    step();
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 20) begin step(); lat++; end
    if (rsp_valid !== 1'b1) begin chk("rsp_valid_timeout", rsp_valid, 1); return; end
    rd = rsp_rdata; er = rsp_err;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'($urandom); req_addr = $urandom; req_be = 4'($urandom);
      step();
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned k = $urandom_range(0, 9);
    int unsigned w = $urandom_range(0, 16);
    if (w == 16) w = 255;
    if (k <= 6) return w * 4;
    if (k == 7) return w * 4 + $urandom_range(1, 3);
    if (k == 8) return 32'h400;
    return ($urandom | 32'h0000_0400) & 32'hFFFF_FFFC;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, v0;
    logic        er;
    int          lat, idx;

    reset = 1'b0;
    repeat (3) step();
    chk("reset_req_ready", req_ready, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_rdata", rsp_rdata, 0);
    chk("reset_rsp_err", rsp_err, 0);
    reset = 1'b1;
    step();
    chk("release_req_ready", req_ready, 1);

    for (int i = 0; i < 17; i++) begin
      idx = (i == 16) ? 255 : i;
      txn(1'b1, 32'(idx * 4), (idx == 8) ? 32'h1111_1111 : $urandom, 4'hF, $urandom_range(0, 2),
          rd, er, lat);
      if (i == 0) v0 = mem_m[0];
    end
    chk("init_word0_model", mem_m[0], v0);

    txn(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, rd, er, lat);
    chk("store_latency", 32'(lat), 3);
    chk("store_rdata", rd, 0);
    chk("store_err", {31'b0, er}, 0);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
    chk("load_latency", 32'(lat), 3);
    chk("load_rdata", rd, 32'hDEAD_BEEF);
    chk("load_err", {31'b0, er}, 0);

    txn(1'b1, 32'h10, 32'h0000_AB00, 4'b0010, 0, rd, er, lat);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
    chk("partial_load", rd, 32'hDEAD_ABEF);

    txn(1'b0, 32'h13, 32'h0, 4'h0, 0, rd, er, lat);
    chk("misalign_err", {31'b0, er}, 1);
    chk("misalign_rdata", rd, 0);

    txn(1'b1, 32'h400, 32'hFFFF_FFFF, 4'hF, 0, rd, er, lat);
    chk("range_err", {31'b0, er}, 1);
    txn(1'b0, 32'h0, 32'h0, 4'h0, 0, rd, er, lat);
    chk("range_word0_kept", rd, v0);

    txn(1'b0, 32'h10, 32'h0, 4'h0, 5, rd, er, lat);
    chk("bp_latency", 32'(lat), 3);
    chk("bp_rdata", rd, 32'hDEAD_ABEF);
    chk("bp_idle_ready", req_ready, 1);
    chk("bp_idle_valid", rsp_valid, 0);

    txn(1'b1, 32'h10, 32'h1234_5678, 4'h0, 0, rd, er, lat);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
    chk("be0_no_change", rd, 32'hDEAD_ABEF);

    // Store accepted, then reset while it waits: it must never land.
    chk("midwait_pre_ready", req_ready, 1);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h5555_AAAA; req_be = 4'hF;
    step();
    req_valid = 1'b0; reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    txn(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat);
    chk("midwait_discard", rd, 32'h1111_1111);

    for (int c = 0; c < 3000; c++) begin
      reset     = ($urandom_range(0, 299) != 0);
      req_valid = 1'($urandom);
      req_we    = 1'($urandom);
      req_addr  = rand_addr();
      req_wdata = $urandom;
      req_be    = 4'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
    repeat (10) step();
    rsp_ready = 1'b0;

    // Zero-wait-state instance.
    step();
    chk("w0_idle_ready", b_req_ready, 1);
    b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 32'h8; b_req_wdata = 32'hCAFE_F00D;
    b_req_be = 4'hF; b_rsp_ready = 1'b1;
    step();
    b_req_valid = 1'b0;
    chk("w0_st_valid_k", b_rsp_valid, 0);
    step();
    chk("w0_st_valid_k1", b_rsp_valid, 1);
    chk("w0_st_rdata", b_rsp_rdata, 0);
    chk("w0_st_err", b_rsp_err, 0);
    step();
    chk("w0_back_ready", b_req_ready, 1);
    chk("w0_back_valid", b_rsp_valid, 0);
    b_req_valid = 1'b1; b_req_we = 1'b0;
    step();
    b_req_valid = 1'b0;
    chk("w0_ld_valid_k", b_rsp_valid, 0);
    step();
    chk("w0_ld_valid_k1", b_rsp_valid, 1);
    chk("w0_ld_rdata", b_rsp_rdata, 32'hCAFE_F00D);
    step();
    b_rsp_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
